// File: rtl/demux1to4_32bit_buf_pkg.sv
// ============================================================================
// demux1to4_32bit_buf_pkg : shared widths, port count and select encodings
// Revision 1.0
// ============================================================================
`default_nettype none

package demux1to4_32bit_buf_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_PORTS = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_OUT1 = 2'b00,
        SEL_OUT2 = 2'b01,
        SEL_OUT3 = 2'b10,
        SEL_OUT4 = 2'b11
    } sel_e;

    function automatic logic [NUM_PORTS-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        case (sel_e'(sel))
            SEL_OUT1: oh = 4'b0001;
            SEL_OUT2: oh = 4'b0010;
            SEL_OUT3: oh = 4'b0100;
            SEL_OUT4: oh = 4'b1000;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_32bit.sv
// ============================================================================
// sync_fifo_32bit : single-clock FIFO, registered head, no bypass
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo_32bit
    import demux1to4_32bit_buf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              w_do_push, w_do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    // Full blocks push even when a pop happens in the same cycle.
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;
    assign head_o    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux1to4_32bit_buf.sv
// ============================================================================
// demux1to4_32bit_buf : routes a valid/ready word stream into one of 4 FIFOs
// Revision 1.0
// ============================================================================
`default_nettype none

module demux1to4_32bit_buf
    import demux1to4_32bit_buf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [SEL_W-1:0]  IN_SELECT,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT1_DATA,
    output logic              OUT1_VALID,
    input  logic              OUT1_READY,
    output logic [DATA_W-1:0] OUT2_DATA,
    output logic              OUT2_VALID,
    input  logic              OUT2_READY,
    output logic [DATA_W-1:0] OUT3_DATA,
    output logic              OUT3_VALID,
    input  logic              OUT3_READY,
    output logic [DATA_W-1:0] OUT4_DATA,
    output logic              OUT4_VALID,
    input  logic              OUT4_READY,
    output logic [31:0]       ACCEPT_COUNT
);

    logic [NUM_PORTS-1:0] w_sel_oh, w_push, w_pop, w_full, w_empty;
    logic [DATA_W-1:0]    w_head [NUM_PORTS];
    logic                 w_accept;
    logic [31:0]          accept_cnt_q, accept_cnt_d;

    assign w_sel_oh = sel_decode(IN_SELECT);
    assign IN_READY = ~w_full[IN_SELECT];
    assign w_accept = IN_VALID & IN_READY;
    assign w_push   = w_sel_oh & {NUM_PORTS{w_accept}};
    assign w_pop    = {OUT4_READY, OUT3_READY, OUT2_READY, OUT1_READY};

    generate
        for (genvar n = 0; n < NUM_PORTS; n++) begin : g_fifo
            sync_fifo_32bit #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk_i   (CLK),
                .rst_ni  (RESET_N),
                .push_i  (w_push[n]),
                .data_i  (IN_DATA),
                .pop_i   (w_pop[n]),
                .full_o  (w_full[n]),
                .empty_o (w_empty[n]),
                .head_o  (w_head[n])
            );
        end
    endgenerate

    assign OUT1_DATA  = w_head[0];
    assign OUT2_DATA  = w_head[1];
    assign OUT3_DATA  = w_head[2];
    assign OUT4_DATA  = w_head[3];
    assign OUT1_VALID = ~w_empty[0];
    assign OUT2_VALID = ~w_empty[1];
    assign OUT3_VALID = ~w_empty[2];
    assign OUT4_VALID = ~w_empty[3];

    always_comb begin
        accept_cnt_d = accept_cnt_q;
        if (w_accept) accept_cnt_d = accept_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) accept_cnt_q <= '0;
        else          accept_cnt_q <= accept_cnt_d;
    end

    assign ACCEPT_COUNT = accept_cnt_q;

endmodule

`default_nettype wire

// File: doc/demux1to4_32bit_buf.md
DEMUX1TO4_32BIT_BUF -- requirements
Module: demux1to4_32bit_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning entries per output FIFO (power of two, 2..16).
REQ-002 The block SHALL have port CLK, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port RESET_N, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have port IN_DATA, input, 32, the word to route.
REQ-005 The block SHALL have port IN_SELECT, input, 2, the destination: 00 to OUT1, 01 to OUT2, 10 to OUT3, 11 to OUT4.
REQ-006 The block SHALL have port IN_VALID, input, 1, meaning IN_DATA/IN_SELECT are valid.
REQ-007 The block SHALL have port IN_READY, output, 1, meaning the selected destination can accept.
REQ-008 The block SHALL have ports OUTn_DATA, output, 32, the head word of FIFO n, for n=1..4.
REQ-009 The block SHALL have ports OUTn_VALID, output, 1, meaning FIFO n is non-empty, for n=1..4.
REQ-010 The block SHALL have ports OUTn_READY, input, 1, the consumer pop request, for n=1..4.
REQ-011 The block SHALL have port ACCEPT_COUNT, output, 32, the total words accepted since reset.

Function
REQ-012 IN_READY SHALL be combinational: high iff the FIFO addressed by the current IN_SELECT is not full; it SHALL NOT depend on IN_VALID.
REQ-013 A push SHALL occur on a rising CLK when IN_VALID and IN_READY are both high; the word SHALL go to the selected FIFO only.
REQ-014 A pop of FIFO n SHALL occur on a rising CLK when OUTn_VALID and OUTn_READY are both high.
REQ-015 Latency: a word pushed into an empty FIFO SHALL appear on OUTn_DATA with OUTn_VALID high in the next cycle; there is no same-cycle bypass.
REQ-016 Each FIFO SHALL preserve arrival order; FIFOs SHALL be mutually independent (back-pressure on one does not stall pushes to another).
REQ-017 Full FIFO: IN_READY SHALL be low for that select even if the same FIFO is popped in the same cycle (no push-through on full).
REQ-018 Simultaneous push and pop on a FIFO that is neither empty nor full SHALL both occur; the occupancy count SHALL be unchanged.
REQ-019 Empty FIFO: OUTn_VALID SHALL be low; OUTn_READY SHALL be ignored and no underflow SHALL occur. OUTn_DATA is don't-care while OUTn_VALID is low.
REQ-020 OUTn_DATA SHALL hold stable while OUTn_VALID is high and OUTn_READY is low.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be log2(DEPTH)+1 bits wide.
REQ-022 ACCEPT_COUNT SHALL increment by 1 per push and SHALL wrap from 0xFFFFFFFF to 0.
REQ-023 A change of IN_SELECT while IN_VALID is high and IN_READY is low SHALL be legal; the push SHALL follow the select present at the accepting edge.

Reset
REQ-024 While RESET_N is low at a rising CLK, all FIFOs SHALL empty (pointers and counts set to 0), all OUTn_VALID SHALL be 0, and ACCEPT_COUNT SHALL be 0.
REQ-025 Reset mid-operation SHALL discard all buffered words; no push or pop SHALL take effect in a reset cycle.
REQ-026 FIFO storage arrays SHALL NOT require reset.
REQ-027 IN_READY SHALL be 1 in the first cycle after reset release.

Structure
REQ-028 The data width (32), the port count (4) and the select encodings SHALL be defined in the shared defines file used by the CPU support modules.
REQ-029 A single sub-module, sync_fifo_32bit (parameter DEPTH; push/pop/full/empty/head), SHALL be instantiated four times.
REQ-030 The top level SHALL contain only select decode, ready mux and ACCEPT_COUNT.

Verification
REQ-031 Reset, then push 0xDEADBEEF with select 10 -> next cycle OUT3_VALID=1, OUT3_DATA=0xDEADBEEF; the other VALIDs are 0; ACCEPT_COUNT=1.
REQ-032 Hold OUT1_READY=0 and push 0x1, then 0x2 to select 00 (DEPTH=2) -> IN_READY=0 for select 00 and 1 for select 01; a third push to OUT1 is not accepted; popping yields 0x1 then 0x2.
REQ-033 FIFO1 full, OUT1_READY=1, IN_VALID=1, select 00 in the same cycle -> pop occurs, no push, count 2->1.
REQ-034 FIFO2 holds 1 word; push and pop FIFO2 in the same cycle -> count stays 1; order is preserved.
REQ-035 Fill FIFO4 with 2 words, assert RESET_N=0 for 1 cycle -> OUT4_VALID=0, ACCEPT_COUNT=0, IN_READY=1 after release.
REQ-036 Preload ACCEPT_COUNT near wrap (force to 0xFFFFFFFF) and push once -> ACCEPT_COUNT=0x00000000.
